// File: rtl/pc_sequencer.sv
// pc_sequencer: five-stage instruction sequencer with next-PC select and a return-address stack.
// Latency: pc updates at the end of WB (5 cycles per instruction); no backpressure, controls are sampled only at the end of WB.
// Optional feature macro PC_SEQ_RESUME_EN adds a resume input that leaves HALTED with pc+1.

module pc_sequencer #(
  parameter int                  PC_WIDTH    = 16,
  parameter int                  STACK_DEPTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          branch,
  input  logic                push,
  input  logic                pop,
  input  logic                add_pc,
  input  logic                brfl_control,
  input  logic                brfl_flag,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic [PC_WIDTH-1:0] reg_target,
  input  logic [PC_WIDTH-1:0] pc_offset,
`ifdef PC_SEQ_RESUME_EN
  input  logic                resume,
`endif
  output logic [PC_WIDTH-1:0] pc,
  output logic [2:0]          stage,
  output logic                fetch_en,
  output logic                write_pc,
  output logic                halted,
  output logic                stack_overflow,
  output logic                stack_underflow
);

  localparam int                  IDX_W   = $clog2(STACK_DEPTH);
  localparam int                  SP_W    = IDX_W + 1;
  localparam logic [SP_W-1:0]     SP_FULL = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0]     SP_ONE  = SP_W'(1);
  localparam logic [IDX_W-1:0]    IDX_ONE = IDX_W'(1);
  localparam logic [PC_WIDTH-1:0] PC_ONE  = PC_WIDTH'(1);

  localparam logic [2:0] BR_JR   = 3'b001;
  localparam logic [2:0] BR_CALL = 3'b010;
  localparam logic [2:0] BR_HALT = 3'b011;
  localparam logic [2:0] BR_JPC  = 3'b100;

  typedef enum logic [2:0] {
    S_IFH    = 3'b000,
    S_ID     = 3'b001,
    S_EX     = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_HALTED = 3'b101
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_nxt;
  logic [SP_W-1:0]     r_sp;
  logic [SP_W-1:0]     w_sp_nxt;
  logic                r_ovf;
  logic                r_unf;
  logic                w_ovf_set;
  logic                w_unf_set;
  logic                w_push;
  logic [PC_WIDTH-1:0] r_stack [STACK_DEPTH];

  logic                w_empty;
  logic                w_full;
  logic [IDX_W-1:0]    w_wr_idx;
  logic [IDX_W-1:0]    w_top_idx;
  logic [PC_WIDTH-1:0] w_top;
  logic [PC_WIDTH-1:0] w_pc_inc;

  assign w_empty   = (r_sp == '0);
  assign w_full    = (r_sp == SP_FULL);
  assign w_wr_idx  = r_sp[IDX_W-1:0];
  // Wraps when the stack is empty, but the top is never used in that case.
  assign w_top_idx = w_wr_idx - IDX_ONE;
  assign w_top     = r_stack[w_top_idx];
  assign w_pc_inc  = r_pc + PC_ONE;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_sp_nxt    = r_sp;
    w_push      = 1'b0;
    w_ovf_set   = 1'b0;
    w_unf_set   = 1'b0;
    case (r_state)
      S_IFH: w_state_nxt = S_ID;
      S_ID:  w_state_nxt = S_EX;
      S_EX:  w_state_nxt = S_MEM;
      S_MEM: w_state_nxt = S_WB;
      S_WB: begin
        w_state_nxt = S_IFH;
        if (branch == BR_HALT) begin
          w_state_nxt = S_HALTED;
        end else if (pop) begin
          // A pop beats any simultaneous push or call.
          if (w_empty) begin
            w_pc_nxt  = w_pc_inc;
            w_unf_set = 1'b1;
          end else begin
            w_sp_nxt = r_sp - SP_ONE;
            w_pc_nxt = add_pc ? (w_top + PC_ONE) : w_top;
          end
        end else if (branch == BR_CALL) begin
          w_pc_nxt = jump_target;
          if (push) begin
            if (w_full) begin
              w_ovf_set = 1'b1;
            end else begin
              w_push   = 1'b1;
              w_sp_nxt = r_sp + SP_ONE;
            end
          end
        end else if (branch == BR_JR) begin
          w_pc_nxt = reg_target;
        end else if (branch == BR_JPC) begin
          w_pc_nxt = r_pc + pc_offset;
        end else if (brfl_control && brfl_flag) begin
          w_pc_nxt = jump_target;
        end else begin
          w_pc_nxt = w_pc_inc;
        end
      end
      S_HALTED: begin
`ifdef PC_SEQ_RESUME_EN
        if (resume) begin
          w_state_nxt = S_IFH;
          w_pc_nxt    = w_pc_inc;
        end
`endif
      end
      default: w_state_nxt = S_IFH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IFH;
      r_pc    <= RESET_PC;
      r_sp    <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_sp    <= w_sp_nxt;
      if (w_ovf_set) r_ovf <= 1'b1;
      if (w_unf_set) r_unf <= 1'b1;
    end
  end

  // Entries need no reset: sp alone defines which ones are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_stack[w_wr_idx] <= r_pc;
  end

  assign pc              = r_pc;
  assign stage           = r_state;
  assign fetch_en        = (r_state == S_IFH);
  assign write_pc        = (r_state == S_WB);
  assign halted          = (r_state == S_HALTED);
  assign stack_overflow  = r_ovf;
  assign stack_underflow = r_unf;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer; resume checks are built only with PC_SEQ_RESUME_EN.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  branch = '0;
  logic        push = 1'b0, pop = 1'b0, add_pc = 1'b0;
  logic        brfl_control = 1'b0, brfl_flag = 1'b0;
  logic [15:0] jump_target = '0, reg_target = '0, pc_offset = '0;
`ifdef PC_SEQ_RESUME_EN
  logic        resume = 1'b0;
`endif
  logic [15:0] pc;
  logic [2:0]  stage;
  logic        fetch_en, write_pc, halted, stack_overflow, stack_underflow;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.PC_WIDTH(16), .STACK_DEPTH(8), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .branch(branch), .push(push), .pop(pop), .add_pc(add_pc),
    .brfl_control(brfl_control), .brfl_flag(brfl_flag), .jump_target(jump_target),
    .reg_target(reg_target), .pc_offset(pc_offset),
`ifdef PC_SEQ_RESUME_EN
    .resume(resume),
`endif
    .pc(pc), .stage(stage), .fetch_en(fetch_en), .write_pc(write_pc), .halted(halted),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_ctl();
    branch = 3'b000; push = 1'b0; pop = 1'b0; add_pc = 1'b0;
    brfl_control = 1'b0; brfl_flag = 1'b0;
    jump_target = '0; reg_target = '0; pc_offset = '0;
  endtask

  task automatic wait_wb();
    int n = 0;
    while (stage !== 3'd4 && n < 8) begin tick(1); n++; end
    if (stage !== 3'd4) begin
      checks++; errors++;
      $display("FAIL wait_wb: stage=%0d required=4", stage);
    end
  endtask

  // Hold the controls for one whole instruction, then return to IFH.
  task automatic exec(input logic [2:0] br, input logic ps, input logic pp, input logic ap,
                      input logic bc, input logic bf, input logic [15:0] jt,
                      input logic [15:0] rt, input logic [15:0] off);
    branch = br; push = ps; pop = pp; add_pc = ap; brfl_control = bc; brfl_flag = bf;
    jump_target = jt; reg_target = rt; pc_offset = off;
    wait_wb();
    tick(1);
    clear_ctl();
  endtask

  task automatic test_reset();
    clear_ctl();
    rst_n = 1'b0;
    tick(2);
    checks++; if (stage !== 3'd0) begin errors++; $display("FAIL reset_stage: got=%0d exp=0", stage); end
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got=%h exp=0000", pc); end
    checks++; if (fetch_en !== 1'b1) begin errors++; $display("FAIL reset_fetch_en: got=%b exp=1", fetch_en); end
    checks++; if (write_pc !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL reset_wp_halt: got=%b%b exp=00", write_pc, halted); end
    checks++; if (stack_overflow !== 1'b0 || stack_underflow !== 1'b0) begin errors++; $display("FAIL reset_flags: got=%b%b exp=00", stack_overflow, stack_underflow); end
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    for (int c = 0; c < 15; c++) begin
      logic [2:0]  es;
      logic [15:0] ep;
      es = 3'(c % 5);
      ep = 16'(c / 5);
      checks++; if (stage !== es) begin errors++; $display("FAIL seq_stage c=%0d: got=%0d exp=%0d", c, stage, es); end
      checks++; if (write_pc !== (es == 3'd4)) begin errors++; $display("FAIL seq_write_pc c=%0d: got=%b exp=%b", c, write_pc, es == 3'd4); end
      checks++; if (fetch_en !== (es == 3'd0)) begin errors++; $display("FAIL seq_fetch_en c=%0d: got=%b exp=%b", c, fetch_en, es == 3'd0); end
      checks++; if (pc !== ep) begin errors++; $display("FAIL seq_pc c=%0d: got=%h exp=%h", c, pc, ep); end
      tick(1);
    end
    checks++; if (pc !== 16'h0003) begin errors++; $display("FAIL seq_pc_end: got=%h exp=0003", pc); end
  endtask

  task automatic test_call_ret();
    exec(3'b001, 0, 0, 0, 0, 0, 16'h0000, 16'h0010, 16'h0000);
    checks++; if (pc !== 16'h0010) begin errors++; $display("FAIL jr_pc: got=%h exp=0010", pc); end
    exec(3'b010, 1, 0, 0, 0, 0, 16'h0040, 16'h0000, 16'h0000);
    checks++; if (pc !== 16'h0040) begin errors++; $display("FAIL call_pc: got=%h exp=0040", pc); end
    exec(3'b000, 0, 1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000);
    checks++; if (pc !== 16'h0011) begin errors++; $display("FAIL ret_add_pc: got=%h exp=0011", pc); end
    exec(3'b010, 1, 0, 0, 0, 0, 16'h0040, 16'h0000, 16'h0000);
    exec(3'b010, 1, 1, 1, 0, 0, 16'h0080, 16'h0000, 16'h0000);
    checks++; if (pc !== 16'h0012) begin errors++; $display("FAIL push_pop_ret_wins: got=%h exp=0012", pc); end
    exec(3'b010, 1, 0, 0, 0, 0, 16'h0040, 16'h0000, 16'h0000);
    exec(3'b000, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
    checks++; if (pc !== 16'h0012) begin errors++; $display("FAIL ret_no_add: got=%h exp=0012", pc); end
    checks++; if (stack_overflow !== 1'b0 || stack_underflow !== 1'b0) begin errors++; $display("FAIL call_ret_flags: got=%b%b exp=00", stack_overflow, stack_underflow); end
  endtask

  task automatic test_jpc();
    exec(3'b001, 0, 0, 0, 0, 0, 16'h0000, 16'h0005, 16'h0000);
    exec(3'b100, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'hFFFE);
    checks++; if (pc !== 16'h0003) begin errors++; $display("FAIL jpc_neg: got=%h exp=0003", pc); end
    exec(3'b100, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0010);
    checks++; if (pc !== 16'h0013) begin errors++; $display("FAIL jpc_pos: got=%h exp=0013", pc); end
    exec(3'b001, 0, 0, 0, 0, 0, 16'h0000, 16'hFFF0, 16'h0000);
    exec(3'b100, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0020);
    checks++; if (pc !== 16'h0010) begin errors++; $display("FAIL jpc_wrap: got=%h exp=0010", pc); end
    exec(3'b001, 0, 0, 0, 0, 0, 16'h0000, 16'hFFFF, 16'h0000);
    exec(3'b000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL pc_inc_wrap: got=%h exp=0000", pc); end
  endtask

  task automatic test_brfl();
    exec(3'b000, 0, 0, 0, 1, 0, 16'h0020, 16'h0000, 16'h0000);
    checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL brfl_not_taken: got=%h exp=0001", pc); end
    exec(3'b000, 0, 0, 0, 1, 1, 16'h0020, 16'h0000, 16'h0000);
    checks++; if (pc !== 16'h0020) begin errors++; $display("FAIL brfl_taken: got=%h exp=0020", pc); end
    exec(3'b001, 0, 0, 0, 1, 1, 16'h0020, 16'h0055, 16'h0000);
    checks++; if (pc !== 16'h0055) begin errors++; $display("FAIL jr_over_brfl: got=%h exp=0055", pc); end
    exec(3'b100, 0, 0, 0, 1, 1, 16'h0020, 16'h0000, 16'h0002);
    checks++; if (pc !== 16'h0057) begin errors++; $display("FAIL jpc_over_brfl: got=%h exp=0057", pc); end
    exec(3'b000, 0, 0, 0, 0, 1, 16'h0020, 16'h0000, 16'h0000);
    checks++; if (pc !== 16'h0058) begin errors++; $display("FAIL flag_without_control: got=%h exp=0058", pc); end
    exec(3'b101, 0, 0, 0, 0, 0, 16'h0020, 16'h0033, 16'h0000);
    checks++; if (pc !== 16'h0059) begin errors++; $display("FAIL unused_branch_seq: got=%h exp=0059", pc); end
  endtask

  task automatic test_sample_window();
    branch = 3'b001; reg_target = 16'h0077; pop = 1'b1; brfl_control = 1'b1; brfl_flag = 1'b1; jump_target = 16'h0020;
    tick(4);
    checks++; if (stage !== 3'd4) begin errors++; $display("FAIL window_stage: got=%0d exp=4", stage); end
    clear_ctl();
    tick(1);
    checks++; if (pc !== 16'h005A) begin errors++; $display("FAIL window_ignored: got=%h exp=005a", pc); end
  endtask

  task automatic test_stack_limits();
    logic [15:0] ep;
    exec(3'b001, 0, 0, 0, 0, 0, 16'h0000, 16'h0100, 16'h0000);
    for (int k = 0; k < 9; k++) begin
      exec(3'b010, 1, 0, 0, 0, 0, 16'h0200 + 16'(k), 16'h0000, 16'h0000);
      checks++; if (pc !== 16'h0200 + 16'(k)) begin errors++; $display("FAIL call_chain k=%0d: got=%h exp=%h", k, pc, 16'h0200 + 16'(k)); end
      checks++; if (stack_overflow !== (k == 8)) begin errors++; $display("FAIL overflow_flag k=%0d: got=%b exp=%b", k, stack_overflow, k == 8); end
    end
    for (int j = 1; j <= 9; j++) begin
      exec(3'b000, 0, 1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000);
      ep = (j <= 7) ? 16'h0208 - 16'(j) : (j == 8) ? 16'h0101 : 16'h0102;
      checks++; if (pc !== ep) begin errors++; $display("FAIL ret_chain j=%0d: got=%h exp=%h", j, pc, ep); end
      checks++; if (stack_underflow !== (j == 9)) begin errors++; $display("FAIL underflow_flag j=%0d: got=%b exp=%b", j, stack_underflow, j == 9); end
    end
    exec(3'b000, 0, 1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000);
    checks++; if (pc !== 16'h0103) begin errors++; $display("FAIL ret_empty_again: got=%h exp=0103", pc); end
    exec(3'b010, 1, 0, 0, 0, 0, 16'h0300, 16'h0000, 16'h0000);
    exec(3'b000, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
    checks++; if (pc !== 16'h0103) begin errors++; $display("FAIL sp_back_to_zero: got=%h exp=0103", pc); end
    checks++; if (stack_overflow !== 1'b1 || stack_underflow !== 1'b1) begin errors++; $display("FAIL sticky_flags: got=%b%b exp=11", stack_overflow, stack_underflow); end
  endtask

  task automatic test_halt();
    branch = 3'b011; pop = 1'b1; add_pc = 1'b1; jump_target = 16'h0777;
    wait_wb();
    checks++; if (write_pc !== 1'b1) begin errors++; $display("FAIL halt_wb_write_pc: got=%b exp=1", write_pc); end
    tick(1);
    branch = 3'b001; reg_target = 16'h0055; pop = 1'b1;
    for (int c = 0; c < 20; c++) begin
      checks++; if (stage !== 3'd5 || halted !== 1'b1) begin errors++; $display("FAIL halted_state c=%0d: got=%0d/%b exp=5/1", c, stage, halted); end
      checks++; if (pc !== 16'h0103) begin errors++; $display("FAIL halted_pc c=%0d: got=%h exp=0103", c, pc); end
      checks++; if (write_pc !== 1'b0 || fetch_en !== 1'b0) begin errors++; $display("FAIL halted_strobes c=%0d: got=%b%b exp=00", c, write_pc, fetch_en); end
      tick(1);
    end
    clear_ctl();
`ifdef PC_SEQ_RESUME_EN
    resume = 1'b1;
    tick(1);
    checks++; if (pc !== 16'h0104 || stage !== 3'd0 || halted !== 1'b0) begin errors++; $display("FAIL resume: got=%h/%0d/%b exp=0104/0/0", pc, stage, halted); end
    exec(3'b000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
    resume = 1'b0;
    checks++; if (pc !== 16'h0105) begin errors++; $display("FAIL resume_ignored_running: got=%h exp=0105", pc); end
`endif
  endtask

  task automatic test_async_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (stage !== 3'd0 || halted !== 1'b0 || pc !== 16'h0000) begin errors++; $display("FAIL reset_from_run: got=%0d/%b/%h exp=0/0/0000", stage, halted, pc); end
    checks++; if (stack_overflow !== 1'b0 || stack_underflow !== 1'b0) begin errors++; $display("FAIL reset_clears_flags: got=%b%b exp=00", stack_overflow, stack_underflow); end
    tick(1);
    rst_n = 1'b1;
    exec(3'b001, 0, 0, 0, 0, 0, 16'h0000, 16'h0099, 16'h0000);
    exec(3'b010, 1, 0, 0, 0, 0, 16'h0044, 16'h0000, 16'h0000);
    checks++; if (pc !== 16'h0044) begin errors++; $display("FAIL pre_reset_call: got=%h exp=0044", pc); end
    pop = 1'b1; add_pc = 1'b1;
    tick(2);
    checks++; if (stage !== 3'd2) begin errors++; $display("FAIL reach_ex: got=%0d exp=2", stage); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (pc !== 16'h0000 || stage !== 3'd0 || fetch_en !== 1'b1) begin errors++; $display("FAIL async_reset_mid_ex: got=%h/%0d/%b exp=0000/0/1", pc, stage, fetch_en); end
    @(posedge clk); #1;
    checks++; if (stage !== 3'd0) begin errors++; $display("FAIL held_in_reset: got=%0d exp=0", stage); end
    rst_n = 1'b1;
    clear_ctl();
    exec(3'b000, 0, 1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000);
    checks++; if (pc !== 16'h0001 || stack_underflow !== 1'b1) begin errors++; $display("FAIL stack_emptied_by_reset: got=%h/%b exp=0001/1", pc, stack_underflow); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_call_ret();
    test_jpc();
    test_brfl();
    test_sample_window();
    test_stack_limits();
    test_halt();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
